// File: rtl/eeg_oram_pkg.sv
// rtl/eeg_oram_pkg.sv - shared state type, default widths and clog2 helper for the ORAM read lane
package eeg_oram_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam int OMUX_ADD_AW_DEF = 8;
  localparam int ORAM_DAT_DW_DEF = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/eeg_oram_pack_fifo.sv
// rtl/eeg_oram_pack_fifo.sv - synchronous word FIFO holding {last, keep, data} packed words
module eeg_oram_pack_fifo
  import eeg_oram_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_dat,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_dat,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;

  assign count = wptr - rptr;
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  // Head is masked while empty so the word outputs read zero out of reset.
  assign pop_dat = empty ? '0 : mem[rptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[PW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/eeg_oram_rd_pack.sv
// rtl/eeg_oram_rd_pack.sv - ORAM lane read sequencer: burst address issue, byte packing, word FIFO
module eeg_oram_rd_pack
  import eeg_oram_pkg::*;
#(
  parameter int OMUX_ADD_AW = OMUX_ADD_AW_DEF,
  parameter int ORAM_DAT_DW = ORAM_DAT_DW_DEF,
  parameter int PACK_NUM    = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            CMD_VLD,
  output logic                            CMD_RDY,
  input  logic [OMUX_ADD_AW-1:0]          CMD_BASE,
  input  logic [OMUX_ADD_AW:0]            CMD_LEN,
  output logic                            ORAM_ADD_VLD,
  output logic                            ORAM_ADD_LST,
  input  logic                            ORAM_ADD_RDY,
  output logic [OMUX_ADD_AW-1:0]          ORAM_ADD_ADD,
  input  logic                            ORAM_DAT_VLD,
  input  logic                            ORAM_DAT_LST,
  output logic                            ORAM_DAT_RDY,
  input  logic [ORAM_DAT_DW-1:0]          ORAM_DAT_DAT,
  output logic                            OUT_VLD,
  input  logic                            OUT_RDY,
  output logic [PACK_NUM*ORAM_DAT_DW-1:0] OUT_DAT,
  output logic [PACK_NUM-1:0]             OUT_KEP,
  output logic                            OUT_LST,
  output logic                            BUSY
);

  localparam int SW = clog2(PACK_NUM);
  localparam int CW = clog2(FIFO_DEPTH) + 1;
  localparam int WW = PACK_NUM * ORAM_DAT_DW;
  localparam int FW = WW + PACK_NUM + 1;

  state_t                 state, state_nxt;
  logic [OMUX_ADD_AW-1:0] addr;
  logic [OMUX_ADD_AW:0]   remain;
  logic [SW-1:0]          slot, pslot;
  logic [CW-1:0]          credit, fifo_cnt;
  logic                   rd_pend, rd_last;
  logic [WW-1:0]          pdat, cap_dat;
  logic [PACK_NUM-1:0]    pkep, cap_kep;
  logic                   add_acc, take_credit, push, pop, fifo_full, fifo_empty;
  logic [FW-1:0]          fifo_out;

  assign ORAM_DAT_RDY = 1'b1;
  assign ORAM_ADD_ADD = addr;
  assign add_acc      = ORAM_ADD_VLD && ORAM_ADD_RDY;
  // A word's FIFO slot is reserved when its first byte address goes out.
  assign take_credit  = add_acc && (slot == '0);
  assign push         = rd_pend && ((pslot == SW'(PACK_NUM - 1)) || rd_last);
  assign pop          = OUT_VLD && OUT_RDY;
  assign OUT_VLD      = !fifo_empty;
  assign {OUT_LST, OUT_KEP, OUT_DAT} = fifo_out;
  assign BUSY         = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    CMD_RDY      = 1'b0;
    ORAM_ADD_VLD = 1'b0;
    ORAM_ADD_LST = 1'b0;
    case (state)
      IDLE: begin
        CMD_RDY = !rst;
        if (CMD_VLD && !rst) state_nxt = ISSUE;
      end
      ISSUE: begin
        ORAM_ADD_VLD = (remain != '0) && ((slot != '0) || (credit != '0));
        ORAM_ADD_LST = (remain == (OMUX_ADD_AW+1)'(1));
        if (ORAM_ADD_VLD && ORAM_ADD_RDY && ORAM_ADD_LST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (push && rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= '0;
      remain  <= '0;
      slot    <= '0;
      rd_pend <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_pend <= add_acc;
      rd_last <= add_acc && ORAM_ADD_LST;
      if (CMD_VLD && CMD_RDY) begin
        addr   <= CMD_BASE;
        remain <= CMD_LEN;
        slot   <= '0;
      end else if (add_acc) begin
        addr   <= addr + 1'b1;
        remain <= remain - 1'b1;
        slot   <= slot + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= CW'(FIFO_DEPTH);
    end else begin
      case ({take_credit, pop})
        2'b10:   credit <= credit - 1'b1;
        2'b01:   credit <= credit + 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  always_comb begin
    cap_dat = pdat;
    cap_kep = pkep;
    cap_dat[pslot*ORAM_DAT_DW +: ORAM_DAT_DW] = ORAM_DAT_DAT;
    cap_kep[pslot] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdat  <= '0;
      pkep  <= '0;
      pslot <= '0;
    end else if (rd_pend) begin
      if (push) begin
        pdat  <= '0;
        pkep  <= '0;
        pslot <= '0;
      end else begin
        pdat  <= cap_dat;
        pkep  <= cap_kep;
        pslot <= pslot + 1'b1;
      end
    end
  end

  eeg_oram_pack_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({rd_last, cap_kep, cap_dat}),
    .pop      (pop),
    .pop_dat  (fifo_out),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  a_dat_vld:  assert property (@(posedge clk) disable iff (rst) rd_pend == ORAM_DAT_VLD);
  a_dat_lst:  assert property (@(posedge clk) disable iff (rst) rd_pend |-> (ORAM_DAT_LST == rd_last));
  a_no_ovf:   assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
  a_len_nz:   assert property (@(posedge clk) disable iff (rst) (CMD_VLD && CMD_RDY) |-> (CMD_LEN != '0));
  a_cnt_rng:  assert property (@(posedge clk) disable iff (rst) fifo_cnt <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_eeg_oram_rd_pack.sv
// tb/tb_eeg_oram_rd_pack.sv - scoreboard bench for eeg_oram_rd_pack with a RAM[i]=i lane model
module tb_eeg_oram_rd_pack;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int PN = 4;
  localparam int FD = 4;
  localparam int OW = PN * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          CMD_VLD = 1'b0;
  logic          CMD_RDY;
  logic [AW-1:0] CMD_BASE = '0;
  logic [AW:0]   CMD_LEN = '0;
  logic          ORAM_ADD_VLD, ORAM_ADD_LST;
  logic          ORAM_ADD_RDY = 1'b1;
  logic [AW-1:0] ORAM_ADD_ADD;
  logic          ORAM_DAT_VLD, ORAM_DAT_LST, ORAM_DAT_RDY;
  logic [DW-1:0] ORAM_DAT_DAT;
  logic          OUT_VLD;
  logic          OUT_RDY = 1'b1;
  logic [OW-1:0] OUT_DAT;
  logic [PN-1:0] OUT_KEP;
  logic          OUT_LST, BUSY;

  typedef struct packed { logic [OW-1:0] dat; logic [PN-1:0] kep; logic lst; } word_t;
  typedef struct packed { logic [AW-1:0] add; logic lst; } addr_t;

  word_t exp_w[$];
  addr_t exp_a[$];
  word_t mon_w;
  addr_t mon_a;
  int    checks = 0;
  int    failures = 0;
  int    acc_cnt = 0;
  int    n;
  logic  bad;

  always #5 clk = ~clk;

  eeg_oram_rd_pack #(
    .OMUX_ADD_AW (AW),
    .ORAM_DAT_DW (DW),
    .PACK_NUM    (PN),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .CMD_VLD      (CMD_VLD),
    .CMD_RDY      (CMD_RDY),
    .CMD_BASE     (CMD_BASE),
    .CMD_LEN      (CMD_LEN),
    .ORAM_ADD_VLD (ORAM_ADD_VLD),
    .ORAM_ADD_LST (ORAM_ADD_LST),
    .ORAM_ADD_RDY (ORAM_ADD_RDY),
    .ORAM_ADD_ADD (ORAM_ADD_ADD),
    .ORAM_DAT_VLD (ORAM_DAT_VLD),
    .ORAM_DAT_LST (ORAM_DAT_LST),
    .ORAM_DAT_RDY (ORAM_DAT_RDY),
    .ORAM_DAT_DAT (ORAM_DAT_DAT),
    .OUT_VLD      (OUT_VLD),
    .OUT_RDY      (OUT_RDY),
    .OUT_DAT      (OUT_DAT),
    .OUT_KEP      (OUT_KEP),
    .OUT_LST      (OUT_LST),
    .BUSY         (BUSY)
  );

  // Lane model: RAM[a] = a, data returned exactly one cycle after address acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ORAM_DAT_VLD <= 1'b0;
      ORAM_DAT_LST <= 1'b0;
      ORAM_DAT_DAT <= '0;
    end else begin
      ORAM_DAT_VLD <= ORAM_ADD_VLD & ORAM_ADD_RDY;
      ORAM_DAT_LST <= ORAM_ADD_VLD & ORAM_ADD_RDY & ORAM_ADD_LST;
      ORAM_DAT_DAT <= (ORAM_ADD_VLD & ORAM_ADD_RDY) ? ORAM_ADD_ADD : '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_w(input logic [OW-1:0] dat, input logic [PN-1:0] kep, input logic lst);
    word_t w;
    w.dat = dat;
    w.kep = kep;
    w.lst = lst;
    exp_w.push_back(w);
  endtask

  task automatic start_cmd(input logic [AW-1:0] base, input int len);
    addr_t a;
    int    k;
    for (int i = 0; i < len; i++) begin
      a.add = base + AW'(i);
      a.lst = (i == len - 1);
      exp_a.push_back(a);
    end
    CMD_BASE = base;
    CMD_LEN  = (AW+1)'(len);
    CMD_VLD  = 1'b1;
    k = 0;
    while (!CMD_RDY && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_accept", CMD_RDY, 1);
    @(negedge clk);
    CMD_VLD = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, output int cyc);
    cyc = 0;
    while ((BUSY || exp_w.size() != 0 || exp_a.size() != 0) && cyc < limit) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk({name, "_busy"}, BUSY, 0);
    chk({name, "_pending"}, exp_w.size() + exp_a.size(), 0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_cmd_rdy"}, CMD_RDY, 0);
    chk({name, "_add_vld"}, ORAM_ADD_VLD, 0);
    chk({name, "_add_lst"}, ORAM_ADD_LST, 0);
    chk({name, "_add_add"}, ORAM_ADD_ADD, 0);
    chk({name, "_out_vld"}, OUT_VLD, 0);
    chk({name, "_out_dat"}, OUT_DAT, 0);
    chk({name, "_out_kep"}, OUT_KEP, 0);
    chk({name, "_out_lst"}, OUT_LST, 0);
    chk({name, "_busy"}, BUSY, 0);
    chk({name, "_dat_rdy"}, ORAM_DAT_RDY, 1);
  endtask

  // Monitor: samples 2 time units after the falling edge, away from drive and clock edges.
  always begin
    @(negedge clk);
    #2;
    if (ORAM_ADD_VLD && ORAM_ADD_RDY) begin
      acc_cnt++;
      if (exp_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL addr_unexpected got=%0h", ORAM_ADD_ADD);
      end else begin
        mon_a = exp_a.pop_front();
        chk("addr", ORAM_ADD_ADD, mon_a.add);
        chk("addr_lst", ORAM_ADD_LST, mon_a.lst);
      end
    end
    if (OUT_VLD && OUT_RDY) begin
      if (exp_w.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL word_unexpected got=%0h", OUT_DAT);
      end else begin
        mon_w = exp_w.pop_front();
        chk("word_dat", OUT_DAT, mon_w.dat);
        chk("word_kep", OUT_KEP, mon_w.kep);
        chk("word_lst", OUT_LST, mon_w.lst);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_rdy", CMD_RDY, 1);

    // Aligned 8-byte burst, back-to-back issue
    push_w(32'h13121110, 4'hf, 1'b0);
    push_w(32'h17161514, 4'hf, 1'b1);
    start_cmd(8'h10, 8);
    wait_done("s1", 100, n);
    chk("s1_busy_cycles", n, 10);

    // Partial last word
    push_w(32'h23222120, 4'hf, 1'b0);
    push_w(32'h00000024, 4'h1, 1'b1);
    start_cmd(8'h20, 5);
    wait_done("s2", 100, n);

    // Address wrap
    push_w(32'h0100fffe, 4'hf, 1'b1);
    start_cmd(8'hfe, 4);
    wait_done("s3", 100, n);

    // Full lane with output blocked: credits stop issue after 16 bytes
    OUT_RDY = 1'b0;
    acc_cnt = 0;
    for (int k = 0; k < 64; k++)
      push_w({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, 4'hf, k == 63);
    start_cmd(8'h00, 256);
    repeat (40) @(negedge clk);
    chk("s4_issued", acc_cnt, 16);
    chk("s4_add_vld", ORAM_ADD_VLD, 0);
    chk("s4_out_vld", OUT_VLD, 1);
    chk("s4_head_dat", OUT_DAT, 32'h03020100);
    OUT_RDY = 1'b1;
    wait_done("s4", 3000, n);

    // Address-ready gap after the second address
    push_w(32'h13121110, 4'hf, 1'b0);
    push_w(32'h17161514, 4'hf, 1'b1);
    start_cmd(8'h10, 8);
    n = 0;
    while (!(ORAM_ADD_VLD && ORAM_ADD_ADD == 8'h12) && n < 20) begin
      @(negedge clk);
      n++;
    end
    ORAM_ADD_RDY = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("s5_gap_vld", ORAM_ADD_VLD, 1);
      chk("s5_gap_add", ORAM_ADD_ADD, 8'h12);
    end
    ORAM_ADD_RDY = 1'b1;
    wait_done("s5", 100, n);

    // Reset in the middle of a burst
    push_w(32'h33323130, 4'hf, 1'b0);
    push_w(32'h37363534, 4'hf, 1'b1);
    start_cmd(8'h30, 8);
    n = 0;
    while (ORAM_ADD_ADD != 8'h33 && n < 20) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    exp_a.delete();
    exp_w.delete();
    #1;
    check_reset("rst1");
    @(negedge clk);
    check_reset("rst1b");
    rst = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (OUT_VLD || ORAM_ADD_VLD || BUSY) bad = 1'b1;
    end
    chk("s6_quiet_after_rst", bad, 0);
    push_w(32'h43424140, 4'hf, 1'b1);
    start_cmd(8'h40, 4);
    wait_done("s6", 100, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eeg_oram_rd_pack.md
Name: eeg_oram_rd_pack

Overview:
Read-side sequencer for one ORAM lane (one ORAM/OMUX pair). It accepts a burst command (base address, byte length) and issues sequential read addresses on the lane's ORAM address channel. It captures the returned bytes and packs them little-endian into PACK_NUM-byte words, then buffers the words for the downstream stream consumer. The ORAM data return has no backpressure, so address issue is governed by word credits against the output FIFO.

Parameters:
OMUX_ADD_AW, 8, ORAM lane address width; lane depth is 2^OMUX_ADD_AW bytes
ORAM_DAT_DW, 8, ORAM byte width
PACK_NUM, 4, bytes per output word; power of 2, at least 2
FIFO_DEPTH, 4, output FIFO depth in words; power of 2, at least 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
CMD_VLD  in  1  command valid
CMD_RDY  out  1  command ready
CMD_BASE  in  OMUX_ADD_AW  first byte address
CMD_LEN  in  OMUX_ADD_AW+1  byte count, 1..2^OMUX_ADD_AW
ORAM_ADD_VLD  out  1  read address valid
ORAM_ADD_LST  out  1  last address of burst
ORAM_ADD_RDY  in  1  read address ready; deasserts when a write has priority
ORAM_ADD_ADD  out  OMUX_ADD_AW  read address
ORAM_DAT_VLD  in  1  read data valid; checked only, not used for capture
ORAM_DAT_LST  in  1  read data last; checked only
ORAM_DAT_RDY  out  1  tied to 1
ORAM_DAT_DAT  in  ORAM_DAT_DW  read data
OUT_VLD  out  1  packed word valid
OUT_RDY  in  1  downstream ready
OUT_DAT  out  PACK_NUM*ORAM_DAT_DW  packed word; byte 0 in the LSBs
OUT_KEP  out  PACK_NUM  byte-valid mask
OUT_LST  out  1  final word of burst
BUSY  out  1  state is not IDLE, or FIFO is not empty

Behaviour:
- Reset: async, active-high. Clears FSM to IDLE, all counters, FIFO pointers, pack register and rd_pend.
- Output values during reset: CMD_RDY=0, ORAM_ADD_VLD=0, ORAM_ADD_LST=0, ORAM_ADD_ADD=0, OUT_VLD=0, OUT_DAT=0, OUT_KEP=0, OUT_LST=0, BUSY=0, ORAM_DAT_RDY=1.
- Reset mid-burst: in-flight return data is discarded, and no word is emitted after reset release.
- IDLE: CMD_RDY=1. CMD_VLD&CMD_RDY latches base into addr and len into remain, clears byte slot index, then goes to ISSUE.
- CMD_LEN=0 is illegal; it is flagged by an assertion only.
- ISSUE, ORAM_ADD_VLD condition: remain>0, and either slot!=0 or word credit>0.
- ISSUE, ORAM_ADD_LST: equals (remain==1).
- ISSUE, on an accepted address:
  - addr increments modulo 2^OMUX_ADD_AW (wraps 0xFF to 0x00).
  - remain decrements.
  - slot increments modulo PACK_NUM.
  - If slot was 0, one word credit is consumed.
- ISSUE exits to DRAIN on acceptance of the last address.
- Credits: counter initialised to FIFO_DEPTH. It decrements on a slot-0 issue and increments on an OUT pop; both in the same cycle leave it unchanged. It never underflows or overflows.
- Capture timing: rd_pend <= address accepted. Data is taken from ORAM_DAT_DAT in the cycle rd_pend=1, i.e. exactly one cycle after acceptance.
- Capture action: the byte is written into pack lane pslot, and its kep bit is set.
- Word push: happens when pslot==PACK_NUM-1 or the captured byte is the burst's last. OUT_LST=1 on the push of the final byte. The kep of a partial last word has only the filled lanes set, and unfilled lanes are zero.
- FIFO full never occurs on a push, because credits guarantee space.
- DRAIN: waits for the final byte's push, then returns to IDLE. New commands are not accepted until DRAIN completes.
- Latency: address accepted at cycle t → byte captured at t+1 → word visible on OUT at t+2 at the earliest.
- Stalls: an ORAM_ADD_RDY low gap only stalls issue, with addr held and VLD held high. A gap between consecutive bytes of a word does not disturb packing.
- Output: standard valid/ready. OUT_DAT, OUT_KEP and OUT_LST stay stable while OUT_VLD=1 and OUT_RDY=0.
- Assertions:
  - rd_pend must equal ORAM_DAT_VLD.
  - ORAM_DAT_LST must match the tracked last flag.
  - No push when the FIFO is full.

Decomposition:
- Shared package eeg_oram_pkg:
  - State enum {IDLE, ISSUE, DRAIN}.
  - Default widths OMUX_ADD_AW and ORAM_DAT_DW.
  - Function clog2.
- Sub-module eeg_oram_pack_fifo: synchronous FIFO, FIFO_DEPTH × (PACK_NUM*ORAM_DAT_DW + PACK_NUM + 1).
  - Outputs: full, empty and count.
  - Write-first bypass is not required.

Test Plan:
- BASE=0x10, LEN=8, RAM[i]=i, OUT_RDY=1 → addresses 0x10..0x17 back-to-back; OUT words 0x13121110 (kep 1111, lst 0) then 0x17161514 (kep 1111, lst 1); BUSY drops after the second pop.
- BASE=0x20, LEN=5 → second word 0x00000024, kep 0001, lst 1; ORAM_ADD_LST only on address 0x24.
- BASE=0xFE, LEN=4 → addresses 0xFE, 0xFF, 0x00, 0x01; single word with kep 1111, lst 1.
- BASE=0, LEN=256, OUT_RDY=0 → exactly 16 addresses issued and then ORAM_ADD_VLD=0 with 4 words queued; releasing OUT_RDY resumes issue, all 64 words delivered in order, lst on word 63.
- LEN=8 with ORAM_ADD_RDY low for 3 cycles after the 2nd address → address held stable during the gap, no duplicate or missing bytes, same two output words as the first scenario.
- rst pulsed after 3 addresses of a LEN=8 burst → all outputs zero during reset; no OUT_VLD after release; a new command completes correctly.
